dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory slave answering the core's DMEM port: registered word read, byte-enable write,
//  read-output reset via DMEM_rst. Sits beside the core in the SoC wrapper, fed directly by the
//  core's MEM stage. Zero-fills its array after reset (scrub FSM); Busy holds the core off meanwhile.
// PARAMETERS
//  DEPTH_WORDS     1024          number of 32-bit words; power of two, >= 4
//  BASE_ADDR       32'h0000_0000 byte address of word 0; 4-byte aligned
//  CLEAR_ON_RESET  1             1: zero-fill array after reset; 0: skip scrub
// PORTS
//  Clk              in   1   clock; all state changes on rising edge
//  Reset            in   1   synchronous, active-high reset
//  DMEM_addr        in   32  byte address from core; bits [1:0] ignored
//  DMEM_wr_byte_en  in   4   lane enables; bit i writes byte lane [8i+7:8i]
//  DMEM_wr_data     in   32  write data, already lane-aligned by core
//  DMEM_wr_en       in   1   write strobe
//  DMEM_rst         in   1   clear read-data register this cycle
//  DMEM_rd_data     out  32  registered read data, 1-cycle latency
//  Busy             out  1   1 while scrubbing; core held in reset by wrapper
//  Addr_fault       out  1   1-cycle pulse: write to out-of-range address
// BEHAVIOUR
//  Reset values: DMEM_rd_data=0, Addr_fault=0, Busy=CLEAR_ON_RESET, scrub counter=0.
//  Decode: off = DMEM_addr - BASE_ADDR (32-bit wrap); in_range = (DMEM_addr >= BASE_ADDR) &&
//   (off < DEPTH_WORDS*4); idx = off[$clog2(DEPTH_WORDS)+1:2].
//  FSM states: CLEAR, READY.
//   Reset -> CLEAR if CLEAR_ON_RESET else READY.
//   CLEAR: mem[cnt] <= 0, cnt++ each cycle; on cnt==DEPTH_WORDS-1 write, go READY next cycle.
//    Busy=1 in all CLEAR cycles (DEPTH_WORDS cycles); Busy=0 from first READY cycle.
//    Core inputs ignored in CLEAR: no writes, DMEM_rd_data held 0, Addr_fault 0.
//   READY: terminal until Reset.
//  READY write: DMEM_wr_en && in_range -> for each i with byte_en[i]=1, mem[idx] lane i <=
//   wr_data lane i; other lanes unchanged. byte_en=4'b0000 -> no change, no fault.
//  READY read: every cycle DMEM_rd_data <= in_range ? mem[idx] : 0 (no read strobe; always reads).
//   Same-cycle read+write same idx: read-first, returns pre-write word; new data next access.
//   DMEM_rst=1: DMEM_rd_data <= 0, overrides read; a write in same cycle still commits.
//  Addr_fault: registered; =1 the cycle after DMEM_wr_en && |byte_en && !in_range; write dropped.
//   Out-of-range reads return 0 and do not fault.
//  Reset priority: Reset over everything. Reset in CLEAR restarts cnt at 0. Reset in READY
//   drops that cycle's write; memory contents otherwise retained until scrub overwrites them.
//  Array inferable as single-port BRAM with byte write enables; no combinational in->out paths.
// TESTING
//  T1 scrub: Reset 1 cycle, DEPTH_WORDS=16 -> Busy=1 exactly 16 cycles, then 0; all words read 0.
//  T2 byte write: word 0x10 = 0, write 0xAABBCCDD byte_en=4'b0101 -> next read 0x00BB00DD.
//  T3 read-first: write 0x12345678 to 0x20 while reading 0x20 (old 0x0) -> rd_data 0x0 next cycle,
//   re-read 0x20 -> 0x12345678.
//  T4 DMEM_rst: word 0x4=0xDEADBEEF, read 0x4 with DMEM_rst=1 -> rd_data 0; next cycle without
//   rst -> 0xDEADBEEF.
//  T5 range: BASE_ADDR=0x1000, DEPTH=16, write 0x1040 -> Addr_fault=1 one cycle, no word changed;
//   read 0x0FFC -> rd_data 0, Addr_fault 0.
//  T6 reset mid-scrub: Reset at cnt=7 -> Busy stays 1 another DEPTH_WORDS cycles; core write
//   during scrub to 0x8 ignored; 0x8 reads 0 after Busy falls.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory slave for the core's DMEM port: registered word reads, byte-lane writes and a
// post-reset zero-fill sweep during which Busy holds the core off.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS    = 1024,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] DMEM_addr,
    input  logic [3:0]  DMEM_wr_byte_en,
    input  logic [31:0] DMEM_wr_data,
    input  logic        DMEM_wr_en,
    input  logic        DMEM_rst,
    output logic [31:0] DMEM_rd_data,
    output logic        Busy,
    output logic        Addr_fault
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [AW-1:0] LastIdx = AW'(DEPTH_WORDS - 1);
    localparam logic [32:0] SpanBytes = 33'(DEPTH_WORDS) << 2;

    typedef enum logic [0:0] {StClear, StReady} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [31:0]   rd_q;
    logic          fault_q, fault_d;

    logic [31:0]   mem [DEPTH_WORDS];
    logic          mem_we;
    logic [AW-1:0] mem_idx;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;

    logic [31:0]   off;
    logic          in_range;
    logic [AW-1:0] idx;

    // 33-bit compare so a span reaching 2^32 bytes cannot wrap.
    assign off      = DMEM_addr - BASE_ADDR;
    assign in_range = (DMEM_addr >= BASE_ADDR) && ({1'b0, off} < SpanBytes);
    assign idx      = off[AW+1:2];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fault_d   = 1'b0;
        mem_we    = 1'b0;
        mem_idx   = idx;
        mem_be    = DMEM_wr_byte_en;
        mem_wdata = DMEM_wr_data;
        unique case (state_q)
            StClear: begin
                mem_we    = 1'b1;
                mem_idx   = cnt_q;
                mem_be    = 4'hF;
                mem_wdata = 32'h0;
                cnt_d     = cnt_q + AW'(1);
                if (cnt_q == LastIdx) begin
                    state_d = StReady;
                end
            end
            StReady: begin
                mem_we  = DMEM_wr_en && in_range;
                fault_d = DMEM_wr_en && (|DMEM_wr_byte_en) && !in_range;
            end
            default: state_d = StReady;
        endcase
        if (Reset) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= CLEAR_ON_RESET ? StClear : StReady;
            cnt_q   <= '0;
            rd_q    <= 32'h0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            // Read-first: the array write below lands on the same edge.
            rd_q    <= (state_q == StReady && !DMEM_rst && in_range) ? mem[idx] : 32'h0;
        end
    end

    always_ff @(posedge Clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) begin
                    mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    assign DMEM_rd_data = rd_q;
    assign Busy         = (state_q == StClear);
    assign Addr_fault   = fault_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: the driver queues the expected outputs for each cycle it
// drives, and a monitor compares them just after the following rising edge.
module tb_dmem_responder;

    localparam logic [31:0] B = 32'h0000_1000;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] DMEM_addr = 32'h0;
    logic [3:0]  DMEM_wr_byte_en = 4'h0;
    logic [31:0] DMEM_wr_data = 32'h0;
    logic        DMEM_wr_en = 1'b0;
    logic        DMEM_rst = 1'b0;
    logic [31:0] DMEM_rd_data;
    logic        Busy;
    logic        Addr_fault;

    typedef struct {
        logic [31:0] rd;
        logic        fault;
        logic        busy;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_fail = 0;

    dmem_responder #(
        .DEPTH_WORDS   (16),
        .BASE_ADDR     (B),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .DMEM_addr      (DMEM_addr),
        .DMEM_wr_byte_en(DMEM_wr_byte_en),
        .DMEM_wr_data   (DMEM_wr_data),
        .DMEM_wr_en     (DMEM_wr_en),
        .DMEM_rst       (DMEM_rst),
        .DMEM_rd_data   (DMEM_rd_data),
        .Busy           (Busy),
        .Addr_fault     (Addr_fault)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge Clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            chk({nm, ".rd_data"}, DMEM_rd_data, e.rd);
            chk({nm, ".fault"}, {31'h0, Addr_fault}, {31'h0, e.fault});
            chk({nm, ".busy"}, {31'h0, Busy}, {31'h0, e.busy});
        end
    end

    task automatic step(input logic rst, input logic [31:0] a, input logic we,
                        input logic [3:0] be, input logic [31:0] wd, input logic drst,
                        input logic [31:0] erd, input logic ef, input logic eb, input string nm);
        exp_t e;
        @(negedge Clk);
        Reset           = rst;
        DMEM_addr       = a;
        DMEM_wr_en      = we;
        DMEM_wr_byte_en = be;
        DMEM_wr_data    = wd;
        DMEM_rst        = drst;
        e.rd    = erd;
        e.fault = ef;
        e.busy  = eb;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] erd, input string nm);
        step(1'b0, a, 1'b0, 4'h0, 32'h0, 1'b0, erd, 1'b0, 1'b0, nm);
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                      input logic [31:0] erd, input logic ef, input string nm);
        step(1'b0, a, 1'b1, be, wd, 1'b0, erd, ef, 1'b0, nm);
    endtask

    logic [31:0] table_after[16];

    initial begin
        // T1: one reset cycle, 16 busy observations, then ready; all words zero.
        step(1'b1, B - 4, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, "reset");
        for (int i = 0; i < 15; i++)
            step(1'b0, B - 4, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, "scrub_busy");
        step(1'b0, B - 4, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, "scrub_done");
        for (int i = 0; i < 16; i++) rd(B + 32'(4 * i), 32'h0, "scrub_zero");

        // T2: byte-lane write.
        wr(B + 32'h10, 4'b0101, 32'hAABB_CCDD, 32'h0, 1'b0, "t2_wr");
        rd(B + 32'h10, 32'h00BB_00DD, "t2_rd");
        // T3: read-first on same word.
        wr(B + 32'h20, 4'hF, 32'h1234_5678, 32'h0, 1'b0, "t3_wr_old");
        rd(B + 32'h20, 32'h1234_5678, "t3_rd_new");
        // T4: DMEM_rst blanks one read.
        wr(B + 32'h4, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0, "t4_wr");
        step(1'b0, B + 32'h4, 1'b0, 4'h0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, "t4_rst");
        rd(B + 32'h4, 32'hDEAD_BEEF, "t4_rd");
        // DMEM_rst with a write: read blanked, write still commits.
        step(1'b0, B + 32'hC, 1'b1, 4'hF, 32'h0BAD_F00D, 1'b1, 32'h0, 1'b0, 1'b0, "rst_wr");
        rd(B + 32'hC, 32'h0BAD_F00D, "rst_wr_rd");
        // Empty byte enable: no change, no fault.
        wr(B + 32'h10, 4'h0, 32'hFFFF_FFFF, 32'h00BB_00DD, 1'b0, "be0_wr");
        rd(B + 32'h10, 32'h00BB_00DD, "be0_rd");
        // Last in-range word, top lane only.
        wr(B + 32'h3C, 4'b1000, 32'h1122_3344, 32'h0, 1'b0, "last_wr");
        rd(B + 32'h3C, 32'h1100_0000, "last_rd");

        // T5: out-of-range accesses.
        wr(B + 32'h40, 4'hF, 32'h5555_5555, 32'h0, 1'b1, "t5_wr_hi");
        rd(B - 4, 32'h0, "t5_rd_lo");
        wr(B + 32'h40, 4'h0, 32'h5555_5555, 32'h0, 1'b0, "t5_be0_nofault");
        wr(B - 4, 4'hF, 32'h6666_6666, 32'h0, 1'b1, "t5_wr_lo");
        rd(B + 32'h8, 32'h0, "t5_fault_pulse");
        foreach (table_after[i]) table_after[i] = 32'h0;
        table_after[1]  = 32'hDEAD_BEEF;
        table_after[3]  = 32'h0BAD_F00D;
        table_after[4]  = 32'h00BB_00DD;
        table_after[8]  = 32'h1234_5678;
        table_after[15] = 32'h1100_0000;
        for (int i = 0; i < 16; i++) rd(B + 32'(4 * i), table_after[i], "t5_unchanged");

        // T6: reset again at cnt=7; writes during scrub are ignored.
        wr(B + 32'h8, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0, "t6_wr");
        rd(B + 32'h8, 32'hCAFE_F00D, "t6_rd");
        step(1'b1, B - 4, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, "t6_reset1");
        for (int i = 0; i < 7; i++)
            step(1'b0, B + 32'h8, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, 1'b1, "t6_busy_a");
        step(1'b1, B - 4, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, "t6_reset2");
        for (int i = 0; i < 15; i++)
            step(1'b0, B + 32'h8, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, 1'b1, "t6_busy_b");
        step(1'b0, B - 4, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, "t6_done");
        for (int i = 0; i < 16; i++) rd(B + 32'(4 * i), 32'h0, "t6_zero");

        repeat (3) @(posedge Clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
